sha3_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `sha3` core between two requesters. It holds the core in reset after system reset, accepts one message at a time, drives the core's request/response handshake, and returns the captured digest to the requester that was granted. It sits between client logic and the `sha3` instance in the `refclk` domain.

---
 rtl/sha3_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sha3_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_arbiter.sv
// sha3_arbiter: round-robin sequencer sharing one sha3 core between two requesters.
// Define SHA3_ARB_TIMEOUT_EN to enable the watchdog and RECOVER path.
module sha3_arbiter #(
  parameter int unsigned MDLEN   = 256,
  parameter int unsigned N       = 344,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             refclk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  input  logic [2*N-1:0]   req_data,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [MDLEN-1:0] rsp_digest,
  output logic             rsp_err,
  output logic             busy,
  output logic             core_rst,
  output logic [N-1:0]     core_md_in,
  output logic             core_req_valid,
  input  logic             core_req_ready,
  input  logic             core_res_valid,
  input  logic [MDLEN-1:0] core_md_out,
  output logic             core_res_ready
);

  localparam logic [2:0] S_RST     = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       stretch_q, stretch_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic [N-1:0]     md_q, md_d;
  logic             creq_q, creq_d;
  logic             cres_q, cres_d;
  logic             crst_q, crst_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [MDLEN-1:0] digest_q, digest_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             win;
  logic             any_req;

`ifdef SHA3_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Requester (last+1) mod 2 has priority; otherwise the other one if active.
  assign any_req   = |req_valid;
  assign win       = req_valid[~last_q] ? ~last_q : last_q;
  assign req_ready = (state_q == S_IDLE && any_req) ? (win ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d     = state_q;
    stretch_d   = stretch_q;
    last_d      = last_q;
    grant_d     = grant_q;
    md_d        = md_q;
    creq_d      = creq_q;
    cres_d      = 1'b0;
    crst_d      = crst_q;
    rsp_valid_d = rsp_valid_q;
    digest_d    = digest_q;
    err_d       = err_q;
    case (state_q)
      S_RST: begin
        crst_d = 1'b1;
        if (stretch_q == 3'd4) begin
          crst_d    = 1'b0;
          stretch_d = '0;
          state_d   = S_IDLE;
        end else begin
          stretch_d = stretch_q + 3'd1;
        end
      end
      S_IDLE: begin
        if (any_req) begin
          md_d    = win ? req_data[2*N-1:N] : req_data[N-1:0];
          grant_d = win;
          creq_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_req_ready) begin
          creq_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_res_valid) begin
          digest_d    = core_md_out;
          err_d       = 1'b0;
          cres_d      = 1'b1;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          state_d     = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          last_d      = grant_q;
          state_d     = S_IDLE;
        end
      end
`ifdef SHA3_ARB_TIMEOUT_EN
      S_RECOVER: begin
        if (stretch_q == 3'd3) begin
          crst_d      = 1'b0;
          stretch_d   = '0;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          state_d     = S_DELIVER;
        end else begin
          stretch_d = stretch_q + 3'd1;
        end
      end
`endif
      default: state_d = S_RST;
    endcase

`ifdef SHA3_ARB_TIMEOUT_EN
    // Watchdog overrides ISSUE/WAIT, but a result arriving on the limit cycle wins.
    to_d = to_q;
    if (state_q == S_IDLE) begin
      to_d = '0;
    end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
      if (to_q == TO_LAST && !(state_q == S_WAIT && core_res_valid)) begin
        state_d   = S_RECOVER;
        creq_d    = 1'b0;
        crst_d    = 1'b1;
        stretch_d = '0;
        digest_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge refclk) begin
    if (!rstn) begin
      state_q     <= S_RST;
      stretch_q   <= '0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      md_q        <= '0;
      creq_q      <= 1'b0;
      cres_q      <= 1'b0;
      crst_q      <= 1'b1;
      rsp_valid_q <= '0;
      digest_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SHA3_ARB_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stretch_q   <= stretch_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      md_q        <= md_d;
      creq_q      <= creq_d;
      cres_q      <= cres_d;
      crst_q      <= crst_d;
      rsp_valid_q <= rsp_valid_d;
      digest_q    <= digest_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef SHA3_ARB_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_digest     = digest_q;
  assign rsp_err        = err_q;
  assign busy           = busy_q;
  assign core_rst       = crst_q;
  assign core_md_in     = md_q;
  assign core_req_valid = creq_q;
  assign core_res_ready = cres_q;

endmodule

// File: tb/tb_sha3_arbiter.sv
// Bench for sha3_arbiter: behavioural stub core plus round-robin reference model.
`timescale 1ns/1ps
module tb_sha3_arbiter;
  localparam int N  = 344;
  localparam int MD = 256;
  localparam logic [N-1:0]  FOX     = "The quick brown fox jumps over the lazy dog";
  localparam logic [MD-1:0] FOX_DIG = 256'h69070dda01975c8c120c3aada1b282394e7f032fa9cf32f4cb2259a0897dfc04;

  logic           refclk = 1'b0;
  logic           rstn;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0] req_data;
  logic [MD-1:0]  rsp_digest;
  logic           rsp_err, busy, core_rst, core_req_valid, core_res_ready;
  logic [N-1:0]   core_md_in;
  logic           core_req_ready = 1'b0;
  logic           core_res_valid = 1'b0;
  logic [MD-1:0]  core_md_out = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last;
  bit stub_mute;

  always #5 refclk = ~refclk;

  sha3_arbiter #(.MDLEN(MD), .N(N), .TIMEOUT(16)) dut (
    .refclk(refclk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digest(rsp_digest), .rsp_err(rsp_err),
    .busy(busy), .core_rst(core_rst), .core_md_in(core_md_in),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_res_valid(core_res_valid), .core_md_out(core_md_out), .core_res_ready(core_res_ready)
  );

  // Stub core digest: the real SHA3-256 value for the fox vector, a fixed mix otherwise.
  function automatic logic [MD-1:0] ref_digest(input logic [N-1:0] m);
    if (m == FOX) return FOX_DIG;
    return m[MD-1:0] ^ m[N-1:N-MD] ^ {8{32'h9e3779b9}};
  endfunction

  function automatic logic [N-1:0] rnd_msg();
    logic [N-1:0] m = '0;
    for (int i = 0; i < 11; i++) m = (m << 32) | N'($urandom);
    return m;
  endfunction

  // Round robin: with both active the one that was not served last wins.
  function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  int stub_ph = 0, stub_wait = 0, res_ready_cnt = 0;
  logic [N-1:0] stub_msg = '0;
  always @(posedge refclk) begin
    if (core_res_ready) res_ready_cnt <= res_ready_cnt + 1;
    if (core_rst) begin
      stub_ph <= 0; core_req_ready <= 1'b0; core_res_valid <= 1'b0;
    end else begin
      case (stub_ph)
        0: if (core_req_valid && $urandom_range(0, 2) != 0) begin
             core_req_ready <= 1'b1; stub_msg <= core_md_in;
             stub_wait <= $urandom_range(1, 8); stub_ph <= 1;
           end
        1: begin
             core_req_ready <= 1'b0;
             if (stub_wait > 0) stub_wait <= stub_wait - 1;
             else if (!stub_mute) begin
               core_res_valid <= 1'b1; core_md_out <= ref_digest(stub_msg); stub_ph <= 2;
             end
           end
        default: if (core_res_ready) begin core_res_valid <= 1'b0; stub_ph <= 0; end
      endcase
    end
  end

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; rsp_ready = '0;
    repeat (2) @(negedge refclk);
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge refclk);
      if (!core_rst) break;
    end
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0; req_valid = 2'b11; rsp_ready = '0;
    repeat (3) @(negedge refclk);
    #1;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset core_rst: got %b want 1", core_rst); end
    n_checks++; if ({req_ready, rsp_valid, rsp_err, core_req_valid, core_res_ready} !== 7'd0) begin
      n_fail++; $display("FAIL reset ctrl outputs: req_ready=%b rsp_valid=%b err=%b creq=%b cres=%b want 0",
                         req_ready, rsp_valid, rsp_err, core_req_valid, core_res_ready); end
    n_checks++; if (rsp_digest !== '0 || core_md_in !== '0) begin
      n_fail++; $display("FAIL reset data: digest=%h md_in=%h want 0", rsp_digest, core_md_in); end
    req_valid = '0; rstn = 1'b1; n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge refclk);
      if (core_rst) n++; else break;
    end
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL reset stretch: got %0d cycles want 4", n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle busy: got %b want 0", busy); end
    model_last = 1'b1;
  endtask

  task automatic test_single();
    logic prev;
    req_data = {rnd_msg(), FOX}; req_valid = 2'b01; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single accept: req_ready=%b want 01", req_ready); end
    @(negedge refclk);
    req_valid = '0;
    n_checks++; if (core_req_valid !== 1'b1 || core_md_in !== FOX) begin
      n_fail++; $display("FAIL single issue: creq=%b md_in=%h want 1/%h", core_req_valid, core_md_in, FOX); end
    prev = 1'b0;
    for (int c = 0; c < 100 && rsp_valid == 2'b00; c++) begin prev = core_res_valid; @(negedge refclk); end
    n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || prev !== 1'b1) begin
      n_fail++; $display("FAIL single rsp: rsp_valid=%b err=%b prev_res=%b want 01/0/1", rsp_valid, rsp_err, prev); end
    n_checks++; if (rsp_digest !== FOX_DIG) begin n_fail++; $display("FAIL single digest: got %h want %h", rsp_digest, FOX_DIG); end
    rsp_ready = 2'b01;
    @(negedge refclk);
    rsp_ready = '0;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single release: rsp_valid=%b want 00", rsp_valid); end
    model_last = 1'b0;
  endtask

  // mode 0: both raised after reset, each dropped once served; 1: both held; 2: random valids.
  task automatic test_round_robin(input int mode, input int njobs);
    logic [1:0] exp; logic [N-1:0] msg; logic prev; bit w; int stall;
    if (mode == 0) do_reset();
    req_data  = {rnd_msg(), rnd_msg()};
    req_valid = (mode == 2) ? 2'b00 : 2'b11;
    for (int j = 0; j < njobs; j++) begin
      exp = '0;
      for (int c = 0; c < 40 && exp == 2'b00; c++) begin
        if (c > 0) @(negedge refclk);
        if (mode == 2) req_valid = 2'($urandom_range(0, 3));
        #1;
        exp = pick(req_valid, model_last);
        n_checks++; if (req_ready !== exp) begin
          n_fail++; $display("FAIL rr%0d job %0d grant: req_ready=%b want %b", mode, j, req_ready, exp); end
      end
      if (exp == 2'b00) break;
      w   = exp[1];
      msg = w ? req_data[2*N-1:N] : req_data[N-1:0];
      @(negedge refclk);
      if (mode == 2) req_valid = '0; else if (mode == 0) req_valid[w] = 1'b0;
      if (w) req_data[2*N-1:N] = rnd_msg(); else req_data[N-1:0] = rnd_msg();
      #1;
      n_checks++; if (core_req_valid !== 1'b1 || core_md_in !== msg || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++; $display("FAIL rr%0d job %0d issue: creq=%b req_ready=%b busy=%b md_ok=%b", mode, j,
                           core_req_valid, req_ready, busy, core_md_in === msg); end
      prev = 1'b0;
      for (int c = 0; c < 100 && rsp_valid == 2'b00; c++) begin prev = core_res_valid; @(negedge refclk); end
      n_checks++; if (rsp_valid !== exp || rsp_err !== 1'b0 || prev !== 1'b1) begin
        n_fail++; $display("FAIL rr%0d job %0d rsp: rsp_valid=%b err=%b prev_res=%b want %b/0/1", mode, j,
                           rsp_valid, rsp_err, prev, exp); end
      n_checks++; if (rsp_digest !== ref_digest(msg)) begin
        n_fail++; $display("FAIL rr%0d job %0d digest: got %h want %h", mode, j, rsp_digest, ref_digest(msg)); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        rsp_ready = ~exp & 2'($urandom_range(0, 3));
        @(negedge refclk);
        n_checks++; if (rsp_valid !== exp || req_ready !== 2'b00) begin
          n_fail++; $display("FAIL rr%0d job %0d stall: rsp_valid=%b req_ready=%b want %b/00", mode, j, rsp_valid, req_ready, exp); end
      end
      rsp_ready = exp | 2'($urandom_range(0, 3)); #1;
      n_checks++; if (req_ready !== 2'b00) begin
        n_fail++; $display("FAIL rr%0d job %0d deliver accept: req_ready=%b want 00", mode, j, req_ready); end
      @(negedge refclk);
      rsp_ready = '0;
      n_checks++; if (rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL rr%0d job %0d release: rsp_valid=%b want 00", mode, j, rsp_valid); end
      model_last = w;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] msg; logic [MD-1:0] d0; bit stable, acc; int base;
    msg = rnd_msg(); req_data = {rnd_msg(), msg}; req_valid = 2'b01; base = res_ready_cnt; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp accept: req_ready=%b want 01", req_ready); end
    @(negedge refclk);
    req_valid = 2'b10; rsp_ready = 2'b10;
    for (int c = 0; c < 100 && rsp_valid == 2'b00; c++) @(negedge refclk);
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL bp rsp: rsp_valid=%b want 01", rsp_valid); end
    d0 = rsp_digest; stable = 1'b1; acc = 1'b0;
    repeat (20) begin
      @(negedge refclk);
      if (rsp_valid !== 2'b01 || rsp_digest !== d0) stable = 1'b0;
      if (req_ready !== 2'b00) acc = 1'b1;
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL bp hold: rsp_valid=%b digest_changed=%b", rsp_valid, rsp_digest !== d0); end
    n_checks++; if (acc) begin n_fail++; $display("FAIL bp accept during job: got 1 want 0"); end
    n_checks++; if (rsp_digest !== ref_digest(msg)) begin n_fail++; $display("FAIL bp digest: got %h want %h", rsp_digest, ref_digest(msg)); end
    n_checks++; if (res_ready_cnt - base != 1) begin n_fail++; $display("FAIL bp core_res_ready pulses: got %0d want 1", res_ready_cnt - base); end
    req_valid = '0; rsp_ready = 2'b01;
    @(negedge refclk);
    rsp_ready = '0;
    model_last = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int n; bit seen;
    stub_mute = 1'b1; req_data = {rnd_msg(), rnd_msg()}; req_valid = 2'b01;
    @(negedge refclk);
    req_valid = '0;
    for (int c = 0; c < 50 && core_req_valid; c++) @(negedge refclk);
    repeat (3) @(negedge refclk);
    n_checks++; if (busy !== 1'b1 || core_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw wait state: busy=%b creq=%b want 1/0", busy, core_req_valid); end
    rstn = 1'b0;
    @(negedge refclk);
    n = core_rst ? 1 : 0; seen = (rsp_valid != 2'b00); rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge refclk);
      if (rsp_valid != 2'b00) seen = 1'b1;
      if (core_rst) n++; else break;
    end
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL rw core_rst length: got %0d want 5", n); end
    repeat (10) begin @(negedge refclk); if (rsp_valid != 2'b00) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rw dropped job: rsp_valid seen=1 want 0"); end
    model_last = 1'b1; stub_mute = 1'b0;
    test_round_robin(2, 2);
  endtask

`ifdef SHA3_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n_wait, n_rst;
    stub_mute = 1'b1; req_data = {rnd_msg(), rnd_msg()}; req_valid = 2'b01;
    @(negedge refclk);
    req_valid = '0; n_wait = 0; n_rst = 0;
    for (int c = 0; c < 100 && rsp_valid == 2'b00; c++) begin
      if (core_rst) n_rst++; else n_wait++;
      @(negedge refclk);
    end
    n_checks++; if (n_wait != 16 || n_rst != 4) begin
      n_fail++; $display("FAIL timeout timing: wait=%0d rst=%0d want 16/4", n_wait, n_rst); end
    n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_digest !== '0) begin
      n_fail++; $display("FAIL timeout rsp: rsp_valid=%b err=%b digest=%h want 01/1/0", rsp_valid, rsp_err, rsp_digest); end
    rsp_ready = 2'b01;
    @(negedge refclk);
    rsp_ready = '0; stub_mute = 1'b0; model_last = 1'b0;
    test_round_robin(2, 2);
  endtask
`endif

  initial begin
    rstn = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '0; stub_mute = 1'b0; model_last = 1'b1;
    test_reset();
    test_single();
    test_round_robin(0, 2);
    test_round_robin(1, 6);
    test_backpressure();
    test_round_robin(2, 8);
    test_reset_in_wait();
`ifdef SHA3_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
